// File: rtl/fifo_feed_ctrl_pkg.sv
// Shared types and helpers for the systolic-array FIFO feed sequencer.
package fifo_feed_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Element and skew counters must hold a full-depth count, hence one extra bit.
  function automatic int cnt_width(input int log_depth);
    return log_depth + 1;
  endfunction

endpackage

// File: rtl/fifo_feed_ctrl_if.sv
// Write-bus and FIFO-array handshake bundle between the feed sequencer and the lane FIFOs.
interface fifo_feed_ctrl_if #(
  parameter int ARRAY_SIZE = 9,
  parameter int DATA_SIZE  = 8
);
  logic                  in_valid;
  logic [DATA_SIZE-1:0]  in_data;
  logic                  in_ready;
  logic                  out_stall;
  logic [ARRAY_SIZE-1:0] fifo_full;
  logic [ARRAY_SIZE-1:0] fifo_empty;
  logic [DATA_SIZE-1:0]  in_bus;
  logic [ARRAY_SIZE-1:0] w_en;
  logic [ARRAY_SIZE-1:0] r_en;
  logic                  fifo_clear;
  logic [ARRAY_SIZE-1:0] lane_valid;

  modport master (
    input  in_valid, in_data, out_stall, fifo_full, fifo_empty,
    output in_ready, in_bus, w_en, r_en, fifo_clear, lane_valid
  );

  modport slave (
    output in_valid, in_data, out_stall, fifo_full, fifo_empty,
    input  in_ready, in_bus, w_en, r_en, fifo_clear, lane_valid
  );
endinterface

// File: rtl/fifo_feed_ctrl_skew_gen.sv
// Diagonal read-enable generator: lane i reads while i <= t < i+len.
module skew_gen #(
  parameter int ARRAY_SIZE = 9,
  parameter int LOG_DEPTH  = 12
) (
  input  logic                  en_i,
  input  logic                  stall_i,
  input  logic [LOG_DEPTH:0]    t_i,
  input  logic [LOG_DEPTH:0]    len_i,
  output logic [ARRAY_SIZE-1:0] r_en_o
);
  localparam int CW = LOG_DEPTH + 2;

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    // One extra bit so i+len cannot wrap for the highest lanes.
    localparam logic [CW-1:0] IDX = CW'(i);
    logic [CW-1:0] t_ext;
    logic [CW-1:0] end_ext;
    assign t_ext     = {1'b0, t_i};
    assign end_ext   = IDX + {1'b0, len_i};
    assign r_en_o[i] = en_i && !stall_i && (t_ext >= IDX) && (t_ext < end_ext);
  end
endmodule

// File: rtl/fifo_feed_ctrl.sv
// Lane-by-lane LOAD then skewed DRAIN sequencer for the systolic FIFO array.
// Optional stall counters: define FIFO_FEED_CTRL_PERF_EN.
module fifo_feed_ctrl
  import fifo_feed_pkg::*;
#(
  parameter int ARRAY_SIZE = 9,
  parameter int DATA_SIZE  = 8,
  parameter int LOG_DEPTH  = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LOG_DEPTH:0] tile_len,
  fifo_feed_ctrl_if.master   bus,
  output logic               busy,
  output logic               done,
  output logic               underflow
`ifdef FIFO_FEED_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_load_stall,
  output logic [31:0]        perf_drain_stall
`endif
);
  localparam int LW  = cnt_width(LOG_DEPTH);
  localparam int LNW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

  state_e                state_q, state_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         el_q, el_d;
  logic [LW-1:0]         t_q, t_d;
  logic [LNW-1:0]        ln_q, ln_d;
  logic                  zdone_q, zdone_d;
  logic                  under_q, under_d;
  logic [ARRAY_SIZE-1:0] lane_valid_q;
  logic [ARRAY_SIZE-1:0] r_en;
  logic [ARRAY_SIZE-1:0] w_en;
  logic                  in_ready;
  logic                  fifo_clear;
  logic [LW-1:0]         last_t;
  logic [DATA_SIZE-1:0]  bus_data;

  assign last_t = len_q + LW'(ARRAY_SIZE - 1) - LW'(1);

  skew_gen #(
    .ARRAY_SIZE (ARRAY_SIZE),
    .LOG_DEPTH  (LOG_DEPTH)
  ) u_skew (
    .en_i    (state_q == ST_DRAIN),
    .stall_i (bus.out_stall),
    .t_i     (t_q),
    .len_i   (len_q),
    .r_en_o  (r_en)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    el_d       = el_q;
    t_d        = t_q;
    ln_d       = ln_q;
    zdone_d    = 1'b0;
    under_d    = under_q | (|(r_en & bus.fifo_empty));
    in_ready   = 1'b0;
    w_en       = '0;
    fifo_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          under_d = 1'b0;
          if (tile_len == '0) begin
            zdone_d = 1'b1;
          end else begin
            len_d   = tile_len;
            el_d    = '0;
            ln_d    = '0;
            t_d     = '0;
            state_d = ST_CLR;
          end
        end
      end
      ST_CLR: begin
        fifo_clear = 1'b1;
        state_d    = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = !bus.fifo_full[ln_q];
        if (bus.in_valid && in_ready) begin
          w_en = {{(ARRAY_SIZE-1){1'b0}}, 1'b1} << ln_q;
          if (el_q == len_q - LW'(1)) begin
            el_d = '0;
            if (ln_q == LNW'(ARRAY_SIZE - 1)) begin
              t_d     = '0;
              state_d = ST_DRAIN;
            end else begin
              ln_d = ln_q + LNW'(1);
            end
          end else begin
            el_d = el_q + LW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!bus.out_stall) begin
          if (t_q == last_t) state_d = ST_DONE;
          else               t_d     = t_q + LW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      el_q         <= '0;
      t_q          <= '0;
      ln_q         <= '0;
      zdone_q      <= 1'b0;
      under_q      <= 1'b0;
      lane_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      el_q         <= el_d;
      t_q          <= t_d;
      ln_q         <= ln_d;
      zdone_q      <= zdone_d;
      under_q      <= under_d;
      lane_valid_q <= r_en;
    end
  end

  assign bus_data       = bus.in_data;
  assign bus.in_bus     = bus_data;
  assign bus.in_ready   = in_ready;
  assign bus.w_en       = w_en;
  assign bus.r_en       = r_en;
  assign bus.fifo_clear = fifo_clear;
  assign bus.lane_valid = lane_valid_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE) || zdone_q;
  assign underflow      = under_q;

`ifdef FIFO_FEED_CTRL_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] perf_ld_q, perf_dr_q;
  logic        perf_clr;
  assign perf_clr = (state_q == ST_IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset || perf_clr) begin
      perf_ld_q <= '0;
      perf_dr_q <= '0;
    end else begin
      if (state_q == ST_LOAD && bus.in_valid && !in_ready) perf_ld_q <= sat_inc(perf_ld_q);
      if (state_q == ST_DRAIN && bus.out_stall)            perf_dr_q <= sat_inc(perf_dr_q);
    end
  end

  assign perf_load_stall  = perf_ld_q;
  assign perf_drain_stall = perf_dr_q;
`endif
endmodule

// File: tb/tb_fifo_feed_ctrl.sv
// Directed bench for fifo_feed_ctrl with ARRAY_SIZE=3, LOG_DEPTH=4.
module tb_fifo_feed_ctrl;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int LD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [LD:0]   tile_len;
  logic          busy, done, underflow;
`ifdef FIFO_FEED_CTRL_PERF_EN
  logic [31:0]   perf_load_stall, perf_drain_stall;
`endif

  fifo_feed_ctrl_if #(.ARRAY_SIZE(N), .DATA_SIZE(DW)) bus ();

  fifo_feed_ctrl #(.ARRAY_SIZE(N), .DATA_SIZE(DW), .LOG_DEPTH(LD)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .tile_len  (tile_len),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .underflow (underflow)
`ifdef FIFO_FEED_CTRL_PERF_EN
    ,
    .perf_load_stall  (perf_load_stall),
    .perf_drain_stall (perf_drain_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Lane model of what was written since the last clear.
  logic [DW-1:0] mem [N][16];
  int            wcnt [N];

  always @(posedge clk) begin
    if (bus.fifo_clear) begin
      for (int i = 0; i < N; i++) wcnt[i] <= 0;
    end else begin
      for (int i = 0; i < N; i++)
        if (bus.w_en[i] && wcnt[i] < 16) begin
          mem[i][wcnt[i]] <= bus.in_bus;
          wcnt[i]         <= wcnt[i] + 1;
        end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Start a tile and stream len*N elements (base, base+1, ...) with no backpressure.
  task automatic load_tile(input int len, input int base);
    tile_len = (LD+1)'(len);
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bus.in_valid = 1'b1;
    for (int k = 0; k < len * N; k++) begin
      bus.in_data = DW'(base + k);
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      if (done) seen = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, done, underflow, bus.in_ready, bus.fifo_clear} !== 5'b0 ||
        bus.w_en !== '0 || bus.r_en !== '0 || bus.lane_valid !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b uf=%b rdy=%b clr=%b w=%b r=%b lv=%b expected all 0",
               busy, done, underflow, bus.in_ready, bus.fifo_clear, bus.w_en, bus.r_en, bus.lane_valid);
    end
  endtask

  task automatic test_load_drain();
    logic [N-1:0] exp_w [6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
    logic [N-1:0] exp_r [4] = '{3'b001, 3'b011, 3'b110, 3'b100};
    logic [N-1:0] prev;
    tile_len = 5'd2;
    start    = 1'b1;
    tick();
    start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd1;
    checks++;
    if (bus.fifo_clear !== 1'b1 || busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_state: clr=%b busy=%b rdy=%b expected 1 1 0", bus.fifo_clear, busy, bus.in_ready);
    end
    tick();
    for (int k = 0; k < 6; k++) begin
      bus.in_data = DW'(k + 1);
      #0;
      checks++;
      if (bus.w_en !== exp_w[k] || bus.in_ready !== 1'b1 || bus.in_bus !== DW'(k + 1) || bus.r_en !== '0) begin
        errors++;
        $display("FAIL load_w_en[%0d]: w=%b rdy=%b bus=%0d r=%b expected w=%b rdy=1 bus=%0d r=000",
                 k, bus.w_en, bus.in_ready, bus.in_bus, bus.r_en, exp_w[k], k + 1);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    prev = '0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.r_en !== exp_r[i] || bus.lane_valid !== prev || bus.w_en !== '0 || done !== 1'b0) begin
        errors++;
        $display("FAIL drain_r_en[%0d]: r=%b lv=%b w=%b done=%b expected r=%b lv=%b w=000 done=0",
                 i, bus.r_en, bus.lane_valid, bus.w_en, done, exp_r[i], prev);
      end
      prev = exp_r[i];
      tick();
    end
    checks++;
    if (done !== 1'b1 || bus.lane_valid !== 3'b100 || bus.r_en !== '0) begin
      errors++;
      $display("FAIL done_pulse: done=%b lv=%b r=%b expected 1 100 000", done, bus.lane_valid, bus.r_en);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || bus.lane_valid !== '0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL after_done: done=%b busy=%b lv=%b uf=%b expected 0 0 000 0", done, busy, bus.lane_valid, underflow);
    end
  endtask

  task automatic test_backpressure();
    int  d = 1;
    bit  seen;
    tile_len = 5'd2;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_data = DW'(d);
      d++;
      tick();
    end
    bus.fifo_full = 3'b010;
    for (int k = 0; k < 3; k++) begin
      bus.in_data = DW'(d);
      #0;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.w_en !== '0) begin
        errors++;
        $display("FAIL full_hold[%0d]: rdy=%b w=%b expected 0 000", k, bus.in_ready, bus.w_en);
      end
      tick();
    end
    bus.fifo_full = '0;
    for (int k = 0; k < 3; k++) begin
      bus.in_data = DW'(d);
      d++;
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (wcnt[0] != 2 || wcnt[1] != 2 || wcnt[2] != 2 ||
        mem[0][0] !== 8'd1 || mem[0][1] !== 8'd2 || mem[1][0] !== 8'd3 ||
        mem[1][1] !== 8'd4 || mem[2][0] !== 8'd5 || mem[2][1] !== 8'd6) begin
      errors++;
      $display("FAIL full_data: cnt=%0d/%0d/%0d l1=%0d,%0d l2=%0d,%0d expected 2/2/2 l1=3,4 l2=5,6",
               wcnt[0], wcnt[1], wcnt[2], mem[1][0], mem[1][1], mem[2][0], mem[2][1]);
    end
`ifdef FIFO_FEED_CTRL_PERF_EN
    checks++;
    if (perf_load_stall !== 32'd3) begin
      errors++;
      $display("FAIL perf_load_stall: got %0d expected 3", perf_load_stall);
    end
`endif
    checks++;
    if (bus.r_en !== 3'b001) begin
      errors++;
      $display("FAIL full_drain_entry: r=%b expected 001", bus.r_en);
    end
    wait_done(20, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL full_done_timeout: done=%b expected 1 within 20 cycles", done);
    end
    tick();
  endtask

  task automatic test_drain_stall();
    logic [N-1:0] exp_r [3] = '{3'b011, 3'b110, 3'b100};
    int cyc = 0;
    load_tile(2, 16);
    checks++;
    if (bus.r_en !== 3'b001) begin
      errors++;
      $display("FAIL stall_t0: r=%b expected 001", bus.r_en);
    end
    tick(); cyc++;
    bus.out_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #0;
      checks++;
      if (bus.r_en !== '0 || done !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: r=%b done=%b expected 000 0", k, bus.r_en, done);
      end
      tick(); cyc++;
    end
    bus.out_stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #0;
      checks++;
      if (bus.r_en !== exp_r[k]) begin
        errors++;
        $display("FAIL stall_resume[%0d]: r=%b expected %b", k, bus.r_en, exp_r[k]);
      end
      tick(); cyc++;
    end
    checks++;
    if (done !== 1'b1 || cyc != 6) begin
      errors++;
      $display("FAIL stall_len: done=%b after %0d drain cycles expected done=1 after 6", done, cyc);
    end
`ifdef FIFO_FEED_CTRL_PERF_EN
    checks++;
    if (perf_drain_stall !== 32'd2) begin
      errors++;
      $display("FAIL perf_drain_stall: got %0d expected 2", perf_drain_stall);
    end
`endif
    tick();
  endtask

  task automatic test_underflow();
    bit seen;
    load_tile(2, 32);
    tick();
    tick();
    bus.fifo_empty = 3'b100;
    #0;
    checks++;
    if (bus.r_en !== 3'b110 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL uf_before: r=%b uf=%b expected 110 0", bus.r_en, underflow);
    end
    tick();
    bus.fifo_empty = '0;
    checks++;
    if (underflow !== 1'b1 || bus.r_en !== 3'b100) begin
      errors++;
      $display("FAIL uf_rise: uf=%b r=%b expected 1 100", underflow, bus.r_en);
    end
    wait_done(10, seen);
    tick();
    checks++;
    if (!seen || underflow !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL uf_sticky: done_seen=%b uf=%b busy=%b expected 1 1 0", seen, underflow, busy);
    end
    tile_len = 5'd2;
    start    = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (underflow !== 1'b0 || bus.fifo_clear !== 1'b1) begin
      errors++;
      $display("FAIL uf_clear: uf=%b clr=%b expected 0 1", underflow, bus.fifo_clear);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_load();
    bit seen;
    tile_len = 5'd2;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_data = DW'(k + 1);
      tick();
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({busy, done, underflow, bus.in_ready, bus.fifo_clear} !== 5'b0 ||
        bus.w_en !== '0 || bus.r_en !== '0 || bus.lane_valid !== '0) begin
      errors++;
      $display("FAIL midload_reset: busy=%b done=%b uf=%b rdy=%b clr=%b w=%b r=%b expected all 0",
               busy, done, underflow, bus.in_ready, bus.fifo_clear, bus.w_en, bus.r_en);
    end
    reset = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.fifo_clear !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midload_idle: clr=%b busy=%b expected 0 0", bus.fifo_clear, busy);
    end
    load_tile(2, 64);
    checks++;
    if (wcnt[0] != 2 || wcnt[1] != 2 || wcnt[2] != 2 || mem[0][0] !== 8'd64 || mem[2][1] !== 8'd69) begin
      errors++;
      $display("FAIL midload_reload: cnt=%0d/%0d/%0d first=%0d last=%0d expected 2/2/2 64 69",
               wcnt[0], wcnt[1], wcnt[2], mem[0][0], mem[2][1]);
    end
    wait_done(10, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL midload_done_timeout: done=%b expected 1 within 10 cycles", done);
    end
    tick();
  endtask

  task automatic test_start_busy_and_zero();
    bit seen;
    tile_len = 5'd2;
    start    = 1'b1;
    tick();
    tile_len = 5'd5;
    tick();
    start = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.in_data = DW'(k + 100);
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.r_en !== 3'b001 || wcnt[0] != 2 || wcnt[1] != 2 || wcnt[2] != 2) begin
      errors++;
      $display("FAIL busy_start: r=%b cnt=%0d/%0d/%0d expected 001 2/2/2", bus.r_en, wcnt[0], wcnt[1], wcnt[2]);
    end
    wait_done(10, seen);
    tick();
    tile_len = 5'd0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.fifo_clear !== 1'b0 || bus.w_en !== '0 || bus.r_en !== '0) begin
      errors++;
      $display("FAIL zero_len_done: done=%b busy=%b clr=%b w=%b r=%b expected 1 0 0 000 000",
               done, busy, bus.fifo_clear, bus.w_en, bus.r_en);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_after: done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    tile_len       = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_stall  = 1'b0;
    bus.fifo_full  = '0;
    bus.fifo_empty = '0;
    for (int i = 0; i < N; i++) wcnt[i] = 0;
    tick();
    test_reset();
    test_load_drain();
    test_backpressure();
    test_drain_stall();
    test_underflow();
    test_reset_mid_load();
    test_start_busy_and_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/fifo_feed_ctrl.md
Name: fifo_feed_ctrl

Overview:
Sequencer for the per-lane FIFO array that feeds the CNN systolic array. It runs in two phases. In LOAD, it streams a tile from the shared write bus into the lanes one after another. In DRAIN, it issues diagonally skewed read enables so that lane i starts i cycles after lane 0. The FIFO array runs on the same clock, with both its r_clk and w_clk tied to clk. The block drives the array's w_en, r_en and clear, and uses its full and empty flags.

Parameters:
ARRAY_SIZE, 9, number of FIFO lanes (systolic rows)
DATA_SIZE, 8, element width in bits
LOG_DEPTH, 12, log2 of per-lane FIFO depth; tile_len is LOG_DEPTH+1 bits wide

Ports:
clk  input  1  single clock for the block and the FIFO array
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; accepted only in IDLE
tile_len  input  LOG_DEPTH+1  elements per lane; sampled on start; legal range 1..2^LOG_DEPTH
in_valid  input  1  write-side data valid
in_data  input  DATA_SIZE  write-side element
in_ready  output  1  block accepts in_data this cycle
out_stall  input  1  array backpressure; freezes DRAIN
fifo_full  input  ARRAY_SIZE  per-lane full flags from the FIFO array
fifo_empty  input  ARRAY_SIZE  per-lane empty flags from the FIFO array
in_bus  output  DATA_SIZE  shared write bus to the FIFOs; equals in_data, combinational
w_en  output  ARRAY_SIZE  one-hot or zero write enable
r_en  output  ARRAY_SIZE  per-lane read enable
fifo_clear  output  1  one-cycle clear pulse to the FIFOs
lane_valid  output  ARRAY_SIZE  r_en delayed one cycle; marks FIFO read data valid
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on DONE
underflow  output  1  sticky error flag; cleared by reset or by an accepted start

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- States:
  - IDLE: on start, latch tile_len into len_q, go to CLR. tile_len=0 on start sets no state change; done pulses the next cycle.
  - CLR: fifo_clear=1 for one cycle, then LOAD.
  - LOAD:
    - lane counter ln (0..ARRAY_SIZE-1) and element counter el (0..len_q-1).
    - in_ready = !fifo_full[ln].
    - Transfer occurs when in_valid && in_ready; w_en = one-hot(ln) on that same cycle.
    - After a transfer, el increments; at el=len_q-1 it wraps to 0 and ln increments.
    - The last transfer (ln=ARRAY_SIZE-1, el=len_q-1) goes to DRAIN with t=0.
  - DRAIN:
    - skew counter t runs 0..len_q+ARRAY_SIZE-2.
    - r_en[i] = !out_stall && (t >= i) && (t < i+len_q).
    - t advances only when out_stall=0.
    - After the cycle with t = len_q+ARRAY_SIZE-2 un-stalled, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- w_en and r_en are never asserted in the same cycle.
- in_ready=0 outside LOAD. start is ignored while busy.
- lane_valid is a register of r_en, so it follows r_en by one cycle.
- Underflow: if r_en[i] is driven while fifo_empty[i]=1, set underflow. The read is still issued; DRAIN timing is unchanged.
- Reset asserted mid-operation: return to IDLE on the next edge. No fifo_clear is issued; the next start clears the FIFOs.
- Counter widths: el and t are LOG_DEPTH+1 bits; t needs no wrap because len_q+ARRAY_SIZE-2 < 2^(LOG_DEPTH+1) by parameter constraint.

Optional Feature:
FIFO_FEED_CTRL_PERF_EN
- Defined: adds outputs perf_load_stall and perf_drain_stall (32 bits each, saturating).
  - perf_load_stall counts LOAD cycles with in_valid && !in_ready.
  - perf_drain_stall counts DRAIN cycles with out_stall=1.
  - Both clear on reset and on an accepted start.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package fifo_feed_pkg holds:
  - state encoding constants ST_IDLE, ST_CLR, ST_LOAD, ST_DRAIN, ST_DONE;
  - the width function for LOG_DEPTH+1.
- Sub-module skew_gen: combinational r_en generation from t, len_q and out_stall, one comparator pair per lane via generate loop.

Test Plan:
1. Load and skewed drain: ARRAY_SIZE=3, tile_len=2, in_valid held high with data 1..6.
   - w_en = 001,001,010,010,100,100.
   - r_en = 001,011,110,100; lane_valid is the same pattern one cycle later.
   - done pulses once, 4 cycles after DRAIN entry.
2. Full backpressure: fifo_full[1]=1 for 3 cycles during lane-1 load.
   - in_ready=0 and w_en=0 for those 3 cycles; el and ln hold.
   - Loading resumes with no element lost or duplicated.
3. Drain stall: out_stall=1 for 2 cycles at t=1.
   - r_en=0 for those cycles; t frozen; pattern resumes unchanged.
   - DRAIN lasts 6 cycles (perf_drain_stall=2 if the macro is defined).
4. Underflow: force fifo_empty[2]=1 while r_en[2] is asserted.
   - underflow rises next cycle and stays high until the next accepted start.
5. Reset mid-LOAD after 3 writes: all outputs 0 the next cycle.
   - A new start yields one fifo_clear pulse, then a normal load.
6. start while busy is ignored, with len_q unchanged.
   - tile_len=0 on start gives no w_en, no r_en, no fifo_clear, and a done pulse one cycle later.
